mips_32bits_iterative_shifter: RTL



---
 rtl/mips_32bits_iterative_shifter_if.sv | 23 ++
 rtl/mips_32bits_iterative_shifter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mips_32bits_iterative_shifter_if.sv
// Request/response bundle between the operand latch, the iterative shifter and the writeback mux.
// The master is the requester and consumer; the slave is the shifter.
interface mips_32bits_iterative_shifter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [4:0]  req_amount;
    logic [1:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output req_valid, req_data, req_amount, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, req_amount, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mips_32bits_iterative_shifter.sv
// Multi-cycle shifter: moves the operand at most STEP positions per clock until the amount is used up.
// Modes: 0 logical left, 1 logical right, 2 arithmetic right, 3 rotate left.
module mips_32bits_iterative_shifter #(
    parameter int STEP  = 1,
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_32bits_iterative_shifter_if.slave bus
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
        $error("mips_32bits_iterative_shifter: STEP must be 1, 2, 4 or 8");
    end
    if (WIDTH != 32) begin : g_bad_width
        $error("mips_32bits_iterative_shifter: only WIDTH = 32 is supported");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [4:0]       remaining;
    logic [1:0]       mode_q;
    logic             sign_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic [4:0]       step_k;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    assign step_k = (remaining < STEP_W) ? remaining : STEP_W;

    // Arithmetic right fills from the sign bit captured at accept, not from the evolving register.
    always_comb begin
        fill_mask = ~({WIDTH{1'b1}} >> step_k);
        shifted   = data_q;
        case (mode_q)
            2'd0:    shifted = data_q << step_k;
            2'd1:    shifted = data_q >> step_k;
            2'd2:    shifted = (data_q >> step_k) | (sign_q ? fill_mask : '0);
            default: shifted = (data_q << step_k) | (data_q >> (6'(WIDTH) - {1'b0, step_k}));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_q      <= '0;
            rsp_data_q  <= '0;
            remaining   <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        data_q      <= bus.req_data;
                        remaining   <= bus.req_amount;
                        mode_q      <= bus.req_mode;
                        sign_q      <= bus.req_data[WIDTH-1];
                        req_ready_q <= 1'b0;
                        if (bus.req_amount == 5'd0) begin
                            state       <= HOLD;
                            rsp_data_q  <= bus.req_data;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    data_q    <= shifted;
                    remaining <= remaining - step_k;
                    if (remaining == step_k) begin
                        state       <= HOLD;
                        rsp_data_q  <= shifted;
                        rsp_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                HOLD: begin
                    // The result register is left untouched so rsp_data keeps its last value.
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule
